dispatch_stage: RTL
===================

# dispatch_stage

In-order dispatch stage sitting directly downstream of the instruction decoder and upstream of the reservation stations. It latches one decoded instruction and holds it while read-after-write or write-after-write hazards exist, tracked by a per-register busy scoreboard. Once clear, it routes the instruction to the reservation station selected by `rs_station` using a valid/ready handshake. Illegal or unknown encodings (`rs_station` 0 or out of range) are dropped and flagged.

## Interface
- `NUM_RS`, 4: number of reservation stations; `rs_station` k (1..NUM_RS) maps to `rs_valid[k-1]`.
- `NUM_REGS`, 32: architectural registers; register 0 is never busy.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decoder output holds a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  struct  decoded instruction. Fields: `operation`[5:0], `alu_fn`[5:0], `rs_station`[3:0], `register_1`/`register_2`/`register_target`[4:0], `has_register_1`/`has_register_2`/`has_target`, `immediate`[15:0], `pc`[31:0].
- `rs_valid`  out  NUM_RS  one-hot dispatch request.
- `rs_ready`  in  NUM_RS  per-station ready.
- `out_instr`  out  struct  held instruction, driven to all stations.
- `wb_valid`  in  1  a writeback completes this cycle.
- `wb_reg`  in  5  destination register of that writeback.
- `flush`  in  1  discard the held instruction.
- `illegal`  out  1  one-cycle pulse when an illegal instruction is dropped.
- `stall_cycles`  out  32  saturating count of cycles the held instruction waited.

## Operation
- States: EMPTY, HOLD. Reset: EMPTY, busy[] all 0, `illegal`=0, `stall_cycles`=0, `rs_valid`=0, `out_instr`=0.
- `in_ready` = EMPTY or (HOLD and fire) or (HOLD and drop). This allows one instruction per cycle.
- Accept (`in_valid`&&`in_ready`): load the holding register and enter or stay in HOLD.
- Effective busy: `busy_eff` = busy & ~(wb_valid ? onehot(wb_reg) : 0). A writeback releases its register in the same cycle.
- Hazard: `has_register_1`&&busy_eff[r1], or `has_register_2`&&busy_eff[r2], or `has_target`&&busy_eff[target]. Register 0 is always treated as not busy.
- `rs_valid[k-1]` = HOLD && !hazard && legal && `rs_station`==k. It never depends on `rs_ready`.
- Fire = `rs_valid[k-1]` && `rs_ready[k-1]`. On fire with `has_target` and target≠0, set busy[target]. If the set and a writeback clear hit the same register, the set wins.
- Legal = 1 ≤ `rs_station` ≤ NUM_RS. Illegal in HOLD: drop the instruction, pulse `illegal` in the same cycle, set no busy bit, and leave HOLD unless a new instruction is accepted.
- HOLD, legal, not fire: `stall_cycles` += 1, saturating at 2^32−1.
- Flush: next state EMPTY, and `in_ready` is forced to 0 that cycle. Busy bits are unchanged because in-flight ops still write back. Flush beats fire: `rs_valid` is forced to 0.
- A writeback to a non-busy register is a no-op.

## Timing
- Accept at edge N → `rs_valid` earliest in cycle N+1. No combinational path from `in_instr` to `rs_valid`.
- Back-to-back independent instructions dispatch on consecutive cycles.
- Dependent instruction: the producer fires in cycle N and the consumer stalls. A writeback in cycle M allows the consumer to fire in cycle M, not M+1.
- `rst` asserted mid-HOLD: the next state is EMPTY with all busy bits cleared, regardless of other inputs.
- `out_instr` is stable while HOLD and not fire.

## Structure
- Shared package `leg_pkg`:
  - `decoded_instr_t` struct.
  - RS id constants `RS_NONE`=0, `RS_ALU`=1, `RS_MULDIV`=2, `RS_BRANCH`=3, `RS_LSU`=4.
  - `REG_W`=5.
- Sub-module `reg_scoreboard`:
  - Inputs: set (valid, reg), clear (valid, reg), and three query ports.
  - Outputs: three busy bits, computed from `busy_eff`.
  - Register 0 is hardwired not busy.
- Top level: holding register, state, routing, illegal pulse, stall counter.

## Test plan
- Reset then addiu (`rs_station`=1, r1=3, target=5), `rs_ready`=4'b1111 → `rs_valid`=4'b0001 one cycle after accept; busy[5]=1.
- Producer target=5, then addu reading r1=5 → `rs_valid` held 0 and `stall_cycles` increments until `wb_valid`=1 with `wb_reg`=5; fire in the same cycle as that writeback.
- lw (`rs_station`=4) with `rs_ready[3]`=0 for 3 cycles → `rs_valid`=4'b1000 stable, `out_instr` stable, `in_ready`=0, `stall_cycles`=3.
- `rs_station`=0 instruction → `illegal` pulse for 1 cycle, `rs_valid`=0, no busy change, next instruction accepted back-to-back.
- Target=0 instruction fires → busy[0] stays 0; a following read of r0 dispatches without stall.
- `flush` while HOLD with `rs_ready`=1 → no dispatch, state EMPTY next cycle, busy bits retained; `rst` mid-HOLD → all busy bits 0.

Source files
------------

// File: rtl/leg_pkg.sv
// Shared types and constants for the decode -> dispatch -> reservation-station path.
package leg_pkg;

  localparam int REG_W = 5;

  localparam logic [3:0] RS_NONE   = 4'd0;
  localparam logic [3:0] RS_ALU    = 4'd1;
  localparam logic [3:0] RS_MULDIV = 4'd2;
  localparam logic [3:0] RS_BRANCH = 4'd3;
  localparam logic [3:0] RS_LSU    = 4'd4;

  typedef struct packed {
    logic [5:0]       operation;
    logic [5:0]       alu_fn;
    logic [3:0]       rs_station;
    logic [REG_W-1:0] register_1;
    logic [REG_W-1:0] register_2;
    logic [REG_W-1:0] register_target;
    logic             has_register_1;
    logic             has_register_2;
    logic             has_target;
    logic [15:0]      immediate;
    logic [31:0]      pc;
  } decoded_instr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits. Queries see same-cycle writebacks; a set beats a clear on the same register.
module reg_scoreboard
  import leg_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [REG_W-1:0] set_reg,
  input  logic             clr_valid,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] q_reg_a,
  input  logic [REG_W-1:0] q_reg_b,
  input  logic [REG_W-1:0] q_reg_c,
  output logic             busy_a,
  output logic             busy_b,
  output logic             busy_c
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask[set_reg] = 1'b1;
    if (clr_valid) clr_mask[clr_reg] = 1'b1;
    busy_eff    = busy_q & ~clr_mask;
    busy_d      = busy_eff | set_mask;
    busy_d[0]   = 1'b0;
    busy_a      = busy_eff[q_reg_a] && (q_reg_a != '0);
    busy_b      = busy_eff[q_reg_b] && (q_reg_b != '0);
    busy_c      = busy_eff[q_reg_c] && (q_reg_c != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/dispatch_stage.sv
// In-order dispatch: holds one decoded instruction until its registers are free, then routes it.
//   state | meaning
//   EMPTY | no instruction held, always ready to accept
//   HOLD  | instruction held, waiting on hazard / station ready, or being dropped
module dispatch_stage
  import leg_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  decoded_instr_t      in_instr,
  output logic [NUM_RS-1:0]   rs_valid,
  input  logic [NUM_RS-1:0]   rs_ready,
  output decoded_instr_t      out_instr,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic                flush,
  output logic                illegal,
  output logic [31:0]         stall_cycles
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] RS_MAX = 4'(NUM_RS);

  state_t         state_q, state_d;
  decoded_instr_t instr_q, instr_d;
  logic [31:0]    stall_q, stall_d;

  logic busy_r1, busy_r2, busy_tgt;
  logic hold, legal, hazard, fire, drop, accept, set_valid;

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_valid),
    .set_reg   (instr_q.register_target),
    .clr_valid (wb_valid),
    .clr_reg   (wb_reg),
    .q_reg_a   (instr_q.register_1),
    .q_reg_b   (instr_q.register_2),
    .q_reg_c   (instr_q.register_target),
    .busy_a    (busy_r1),
    .busy_b    (busy_r2),
    .busy_c    (busy_tgt)
  );

  always_comb begin
    hold   = (state_q == HOLD);
    legal  = (instr_q.rs_station != RS_NONE) && (instr_q.rs_station <= RS_MAX);
    hazard = (instr_q.has_register_1 && busy_r1) ||
             (instr_q.has_register_2 && busy_r2) ||
             (instr_q.has_target     && busy_tgt);

    // Routing depends only on held state and the scoreboard, never on rs_ready or in_instr.
    rs_valid = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      rs_valid[k] = hold && legal && !hazard && !flush &&
                    (instr_q.rs_station == 4'(k + 1));
    end

    fire      = |(rs_valid & rs_ready);
    drop      = hold && !legal;
    illegal   = drop;
    set_valid = fire && instr_q.has_target && (instr_q.register_target != '0);
    in_ready  = !flush && (!hold || fire || drop);
    accept    = in_valid && in_ready;

    state_d = state_q;
    instr_d = instr_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = HOLD;
      instr_d = in_instr;
    end else if (fire || drop) begin
      state_d = EMPTY;
    end

    stall_d = stall_q;
    if (hold && legal && !fire && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  assign out_instr    = instr_q;
  assign stall_cycles = stall_q;

endmodule
